// File: rtl/ongoru_takip.sv
// In-order tracker for gshare-predicted control-flow instructions: checks each prediction at
// decode resolve, updates the predictor and redirects fetch on a miss. ONGORU_ISTATISTIK_EN adds counters.
module ongoru_takip #(
  parameter int KUYRUK_DERINLIGI = 8,
  parameter int PS_GENISLIGI     = 32
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    getir_gecerli_i,
  input  logic [PS_GENISLIGI-1:0] getir_ps_i,
  input  logic                    getir_ongoru_i,
  input  logic [PS_GENISLIGI-1:0] getir_hedef_ps_i,
  output logic                    getir_hazir_o,
  input  logic                    coz_gecerli_i,
  input  logic                    coz_dallanma_oldu_i,
  input  logic [PS_GENISLIGI-1:0] coz_hedef_ps_i,
  input  logic                    temizle_i,
  output logic                    gs_guncelle_o,
  output logic [PS_GENISLIGI-1:0] gs_dallanma_olan_ps_o,
  output logic [PS_GENISLIGI-1:0] gs_dallanilan_ps_o,
  output logic                    gs_dallanma_oldu_o,
  output logic                    yanlis_ongoru_o,
  output logic [PS_GENISLIGI-1:0] duzeltme_ps_o,
  output logic                    bos_cozum_hata_o
`ifdef ONGORU_ISTATISTIK_EN
  ,
  output logic [31:0]             cozulen_sayisi_o,
  output logic [31:0]             yanlis_sayisi_o
`endif
);

  localparam int AW = (KUYRUK_DERINLIGI > 1) ? $clog2(KUYRUK_DERINLIGI) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DERINLIK = CW'(KUYRUK_DERINLIGI);

  // Handshake: a push is taken when getir_gecerli_i && getir_hazir_o at a rising edge;
  // the resolve side has no ready and is honoured only while an entry exists.
  logic [PS_GENISLIGI-1:0] kuyruk_ps_q    [KUYRUK_DERINLIGI];
  logic                    kuyruk_ongoru_q[KUYRUK_DERINLIGI];
  logic [PS_GENISLIGI-1:0] kuyruk_hedef_q [KUYRUK_DERINLIGI];

  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic guncelle_q, guncelle_d, oldu_q, oldu_d, yanlis_q, yanlis_d, hata_q, hata_d;
  logic [PS_GENISLIGI-1:0] olan_q, olan_d, dallanilan_q, dallanilan_d, duzeltme_q, duzeltme_d;

  logic                    getir_kabul, cozum, yanlis_ongoru;
  logic [PS_GENISLIGI-1:0] bas_ps, bas_hedef, gercek_ps;
  logic                    bas_ongoru;

  assign getir_hazir_o = (count_q != DERINLIK);

  always_comb begin
    getir_kabul   = getir_gecerli_i && getir_hazir_o;
    cozum         = coz_gecerli_i && (count_q != '0);
    bas_ps        = kuyruk_ps_q[head_q];
    bas_ongoru    = kuyruk_ongoru_q[head_q];
    bas_hedef     = kuyruk_hedef_q[head_q];
    gercek_ps     = coz_dallanma_oldu_i ? coz_hedef_ps_i : bas_ps + PS_GENISLIGI'(4);
    yanlis_ongoru = cozum && ((bas_ongoru != coz_dallanma_oldu_i) ||
                    (coz_dallanma_oldu_i && bas_ongoru && (bas_hedef != coz_hedef_ps_i)));

    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    guncelle_d   = 1'b0;
    yanlis_d     = 1'b0;
    olan_d       = olan_q;
    dallanilan_d = dallanilan_q;
    oldu_d       = oldu_q;
    duzeltme_d   = duzeltme_q;
    hata_d       = hata_q;

    if (temizle_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (coz_gecerli_i && (count_q == '0)) hata_d = 1'b1;
      if (cozum) begin
        guncelle_d   = 1'b1;
        olan_d       = bas_ps;
        dallanilan_d = gercek_ps;
        oldu_d       = coz_dallanma_oldu_i;
      end
      // A miss squashes every younger entry, including one pushed this very cycle.
      if (yanlis_ongoru) begin
        yanlis_d   = 1'b1;
        duzeltme_d = gercek_ps;
        head_d     = '0;
        tail_d     = '0;
        count_d    = '0;
      end else begin
        head_d  = head_q + AW'(cozum);
        tail_d  = tail_q + AW'(getir_kabul);
        count_d = count_q + CW'(getir_kabul) - CW'(cozum);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      guncelle_q   <= 1'b0;
      yanlis_q     <= 1'b0;
      olan_q       <= '0;
      dallanilan_q <= '0;
      oldu_q       <= 1'b0;
      duzeltme_q   <= '0;
      hata_q       <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      guncelle_q   <= guncelle_d;
      yanlis_q     <= yanlis_d;
      olan_q       <= olan_d;
      dallanilan_q <= dallanilan_d;
      oldu_q       <= oldu_d;
      duzeltme_q   <= duzeltme_d;
      hata_q       <= hata_d;
    end
  end

  // Entry storage needs no reset: count_q alone decides which slots are live.
  always_ff @(posedge clk_i) begin
    if (getir_kabul) begin
      kuyruk_ps_q[tail_q]     <= getir_ps_i;
      kuyruk_ongoru_q[tail_q] <= getir_ongoru_i;
      kuyruk_hedef_q[tail_q]  <= getir_hedef_ps_i;
    end
  end

  assign gs_guncelle_o         = guncelle_q;
  assign gs_dallanma_olan_ps_o = olan_q;
  assign gs_dallanilan_ps_o    = dallanilan_q;
  assign gs_dallanma_oldu_o    = oldu_q;
  assign yanlis_ongoru_o       = yanlis_q;
  assign duzeltme_ps_o         = duzeltme_q;
  assign bos_cozum_hata_o      = hata_q;

`ifdef ONGORU_ISTATISTIK_EN
  logic [31:0] cozulen_q, cozulen_d, yanlis_say_q, yanlis_say_d;

  always_comb begin
    cozulen_d    = cozulen_q;
    yanlis_say_d = yanlis_say_q;
    if (!temizle_i && cozum && (cozulen_q != 32'hFFFF_FFFF)) cozulen_d = cozulen_q + 32'd1;
    if (!temizle_i && yanlis_ongoru && (yanlis_say_q != 32'hFFFF_FFFF))
      yanlis_say_d = yanlis_say_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cozulen_q    <= '0;
      yanlis_say_q <= '0;
    end else begin
      cozulen_q    <= cozulen_d;
      yanlis_say_q <= yanlis_say_d;
    end
  end

  assign cozulen_sayisi_o = cozulen_q;
  assign yanlis_sayisi_o  = yanlis_say_q;
`endif

endmodule
